// File: rtl/strobe_sample_source.sv
// Sample source for the moving-average filters: buffers host samples in a small FIFO
// and replays them as one-cycle strobed words at a programmable, evenly spaced rate.
module strobe_sample_source #(
    parameter int DATA_LEN  = 10,
    parameter int FIFO_AW   = 2,
    parameter int DIV_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_LEN-1:0]   in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  enable,
    input  logic [DIV_WIDTH-1:0]  rate_div,
    input  logic                  clear_underrun,
    output logic [DATA_LEN-1:0]   data_o,
    output logic                  strobe_o,
    output logic [FIFO_AW:0]      fifo_level,
    output logic                  underrun
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] LEVEL_FULL = (FIFO_AW+1)'(DEPTH);

    logic [DATA_LEN-1:0]  mem [DEPTH];
    logic [FIFO_AW-1:0]   wr_ptr;
    logic [FIFO_AW-1:0]   rd_ptr;
    logic [FIFO_AW:0]     level;
    logic [DIV_WIDTH-1:0] cnt;

    logic full;
    logic empty;
    logic push;
    logic tick;
    logic pop;

    // Handshake and pop decisions use registered level only, so in_ready has
    // no combinational dependence on in_valid or on a same-cycle pop.
    assign full  = (level == LEVEL_FULL);
    assign empty = (level == '0);
    assign push  = in_valid && !full;
    assign tick  = enable && (cnt == '0);
    assign pop   = tick && !empty;

    assign in_ready   = !full;
    assign fifo_level = level;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // Rate divider: terminal count at zero, reload with rate_div.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!enable || cnt == '0) begin
            cnt <= rate_div;
        end else begin
            cnt <= cnt - DIV_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + FIFO_AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + FIFO_AW'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + (FIFO_AW+1)'(1);
                2'b01:   level <= level - (FIFO_AW+1)'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_o   <= '0;
            strobe_o <= 1'b0;
            underrun <= 1'b0;
        end else begin
            strobe_o <= pop;
            if (pop) begin
                data_o <= mem[rd_ptr];
            end
            // A starved tick outranks a coincident clear.
            if (tick && empty) begin
                underrun <= 1'b1;
            end else if (clear_underrun) begin
                underrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_strobe_sample_source.sv
// Directed bench for strobe_sample_source: expected strobes (cycle, data) are queued by
// the stimulus and consumed by an independent monitor on every observed strobe.
module tb_strobe_sample_source;

    logic       clk;
    logic       rst_n;
    logic [9:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       enable;
    logic [7:0] rate_div;
    logic       clear_underrun;
    logic [9:0] data_o;
    logic       strobe_o;
    logic [2:0] fifo_level;
    logic       underrun;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int         exp_cyc  [$];
    logic [9:0] exp_data [$];

    strobe_sample_source #(.DATA_LEN(10), .FIFO_AW(2), .DIV_WIDTH(8)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .enable(enable),
        .rate_div(rate_div),
        .clear_underrun(clear_underrun),
        .data_o(data_o),
        .strobe_o(strobe_o),
        .fifo_level(fifo_level),
        .underrun(underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_strobe(input int c, input logic [9:0] d);
        exp_cyc.push_back(c);
        exp_data.push_back(d);
    endtask

    // Monitor: every strobe must match the head of the expectation queue.
    always @(negedge clk) begin
        if (rst_n && strobe_o) begin
            if (exp_cyc.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: data 0x%0h at cycle %0d, none expected", data_o, cyc);
            end else begin
                automatic int         ec = exp_cyc.pop_front();
                automatic logic [9:0] ed = exp_data.pop_front();
                chk("strobe_cycle", cyc, ec);
                chk("strobe_data", int'(data_o), int'(ed));
            end
        end
    end

    initial begin
        automatic logic [9:0] vals [4] = '{10'h001, 10'h155, 10'h2AA, 10'h3FF};
        automatic int e;

        rst_n = 1'b0;
        in_data = '0;
        in_valid = 1'b0;
        enable = 1'b0;
        rate_div = '0;
        clear_underrun = 1'b0;
        step(2);
        chk("reset_in_ready", int'(in_ready), 1);
        chk("reset_level", int'(fifo_level), 0);
        rst_n = 1'b1;

        // idle after reset
        for (int i = 0; i < 20; i++) begin
            step(1);
            chk("idle_in_ready", int'(in_ready), 1);
            chk("idle_level", int'(fifo_level), 0);
            chk("idle_strobe", int'(strobe_o), 0);
            chk("idle_data", int'(data_o), 0);
            chk("idle_underrun", int'(underrun), 0);
        end

        // fill, offer a fifth sample while full, then play out at rate_div=3
        rate_div = 8'd3;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = vals[i];
            step(1);
        end
        chk("full_level", int'(fifo_level), 4);
        chk("full_in_ready", int'(in_ready), 0);
        in_data = 10'h0AB;
        step(3);
        chk("full_hold_level", int'(fifo_level), 4);
        chk("full_hold_in_ready", int'(in_ready), 0);
        e = cyc;
        enable = 1'b1;
        for (int i = 0; i < 4; i++) expect_strobe(e + 4 + 4*i, vals[i]);
        expect_strobe(e + 20, 10'h0AB);
        step(4);
        chk("first_pop_level", int'(fifo_level), 3);
        chk("first_pop_in_ready", int'(in_ready), 1);
        step(1);
        chk("refill_level", int'(fifo_level), 4);
        chk("refill_in_ready", int'(in_ready), 0);
        in_valid = 1'b0;
        step(3);
        chk("second_pop_level", int'(fifo_level), 3);
        step(12);
        chk("drained_level", int'(fifo_level), 0);
        chk("drained_underrun", int'(underrun), 0);
        enable = 1'b0;
        step(2);

        // rate_div=0 streaming 0x000..0x00F
        rate_div = 8'd0;
        step(1);
        e = cyc;
        enable = 1'b1;
        in_valid = 1'b1;
        in_data = 10'h000;
        for (int v = 0; v < 16; v++) expect_strobe(e + 2 + v, 10'(v));
        for (int k = 1; k <= 16; k++) begin
            step(1);
            if (k == 1) begin
                chk("prime_underrun", int'(underrun), 1);
                chk("prime_level", int'(fifo_level), 1);
                clear_underrun = 1'b1;
            end
            if (k == 2) begin
                clear_underrun = 1'b0;
                chk("stream_underrun_cleared", int'(underrun), 0);
            end
            if (k == 8) begin
                chk("stream_level", int'(fifo_level), 1);
                chk("stream_in_ready", int'(in_ready), 1);
            end
            if (k < 16) in_data = 10'(k);
            else in_valid = 1'b0;
        end
        step(1);
        chk("stream_end_underrun", int'(underrun), 0);
        chk("stream_end_level", int'(fifo_level), 0);
        enable = 1'b0;
        step(2);

        // starved playback and underrun clearing, rate_div=2
        rate_div = 8'd2;
        step(1);
        enable = 1'b1;
        step(2);
        chk("starve_before_tick", int'(underrun), 0);
        step(1);
        chk("starve_tick", int'(underrun), 1);
        clear_underrun = 1'b1;
        step(1);
        clear_underrun = 1'b0;
        chk("clear_non_tick", int'(underrun), 0);
        step(1);
        clear_underrun = 1'b1;
        step(1);
        clear_underrun = 1'b0;
        chk("clear_on_tick_set_wins", int'(underrun), 1);
        enable = 1'b0;
        step(1);
        clear_underrun = 1'b1;
        step(1);
        clear_underrun = 1'b0;
        chk("clear_disabled", int'(underrun), 0);

        // asynchronous reset right after the first strobe
        rate_div = 8'd1;
        in_valid = 1'b1;
        in_data = 10'h111;
        step(1);
        in_data = 10'h222;
        step(1);
        in_data = 10'h333;
        step(1);
        in_valid = 1'b0;
        chk("rst_load_level", int'(fifo_level), 3);
        e = cyc;
        enable = 1'b1;
        expect_strobe(e + 2, 10'h111);
        step(2);
        chk("rst_pre_strobe", int'(strobe_o), 1);
        chk("rst_pre_data", int'(data_o), 10'h111);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_strobe", int'(strobe_o), 0);
        chk("async_rst_data", int'(data_o), 0);
        chk("async_rst_level", int'(fifo_level), 0);
        chk("async_rst_in_ready", int'(in_ready), 1);
        step(2);
        rst_n = 1'b1;
        step(10);
        chk("post_rst_level", int'(fifo_level), 0);
        chk("post_rst_data", int'(data_o), 0);
        chk("pending_strobes", exp_cyc.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
